// File: rtl/spmv_row_dispatch.sv
// Row dispatcher for a CISR-style SpMV engine: hands row lengths from one stream
// to NUM_CH channels in round-robin order. Optional statistics: SPMV_DISPATCH_STATS_EN.
module spmv_row_dispatch #(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 32,
  parameter int DIM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  num_rows,
  input  logic              rl_valid,
  input  logic [DATA_W-1:0] rl_data,
  output logic              rl_ready,
  input  logic [NUM_CH-1:0] ch_req,
  input  logic [NUM_CH-1:0] ch_idle,
  output logic [NUM_CH-1:0] grant,
  output logic [DATA_W-1:0] grant_row_len,
  output logic [DIM_W-1:0]  grant_row_idx,
  output logic              spmv_init,
  output logic              busy,
  output logic              done,
  output logic [DIM_W-1:0]  stat_rows,
  output logic [31:0]       stat_stalls,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PTR_W:0]   NUM_CH_L = (PTR_W + 1)'(NUM_CH);
  localparam logic [PTR_W-1:0] LAST_CH  = PTR_W'(NUM_CH - 1);

  state_t            state, state_nxt;
  logic [DIM_W-1:0]  rows_q, issued_q, idx_q;
  logic [PTR_W-1:0]  ptr_q, win, ptr_nxt;
  logic [PTR_W:0]    cand_sum;
  logic [PTR_W-1:0]  cand;
  logic [NUM_CH-1:0] eligible, win_oh;
  logic              win_found, take;

  // The channel granted last cycle still shows its stale request, so mask it.
  assign eligible = ch_req & ~grant;

  always_comb begin
    win       = '0;
    win_found = 1'b0;
    cand_sum  = '0;
    cand      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand_sum = {1'b0, ptr_q} + (PTR_W + 1)'(i);
      if (cand_sum >= NUM_CH_L) cand_sum = cand_sum - NUM_CH_L;
      cand = cand_sum[PTR_W-1:0];
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win       = cand;
      end
    end
  end

  assign win_oh  = NUM_CH'(1) << win;
  assign ptr_nxt = (win == LAST_CH) ? '0 : win + PTR_W'(1);

  // Handshake: a row length transfers on any cycle where rl_valid and rl_ready
  // are both high; rl_ready never waits on anything registered from rl_valid.
  assign take     = (state == RUN) && rl_valid && win_found && (issued_q < rows_q);
  assign rl_ready = take;

  assign busy      = (state == RUN) || (state == DRAIN);
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_rows == '0) ? DONE : RUN;
      RUN:     if (take && (issued_q + DIM_W'(1) == rows_q)) state_nxt = DRAIN;
      DRAIN:   if ((&ch_idle) && (grant == '0)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rows_q        <= '0;
      issued_q      <= '0;
      idx_q         <= '0;
      ptr_q         <= '0;
      grant         <= '0;
      grant_row_len <= '0;
      grant_row_idx <= '0;
      spmv_init     <= 1'b0;
      done          <= 1'b0;
    end else begin
      state     <= state_nxt;
      spmv_init <= (state == IDLE) && start;
      done      <= (state == DONE);
      grant     <= '0;
      if ((state == IDLE) && start) begin
        rows_q   <= num_rows;
        issued_q <= '0;
        idx_q    <= '0;
      end
      if (take) begin
        grant         <= win_oh;
        grant_row_len <= rl_data;
        grant_row_idx <= idx_q;
        idx_q         <= idx_q + DIM_W'(1);
        issued_q      <= issued_q + DIM_W'(1);
        ptr_q         <= ptr_nxt;
      end
    end
  end

`ifdef SPMV_DISPATCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rows   <= '0;
      stat_stalls <= '0;
    end else if ((state == IDLE) && start) begin
      stat_rows   <= '0;
      stat_stalls <= '0;
    end else begin
      if (take) stat_rows <= stat_rows + DIM_W'(1);
      if ((state == RUN) && rl_valid && (eligible == '0)) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`else
  assign stat_rows   = '0;
  assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_spmv_row_dispatch.sv
// Bench for spmv_row_dispatch: directed cycle table, then randomized jobs checked
// against a transaction-level model (grant order, row index, stall/row counts).
module tb_spmv_row_dispatch;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int DIM_W  = 16;
`ifdef SPMV_DISPATCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DIM_W-1:0]  num_rows = '0;
  logic              rl_valid = 1'b0;
  logic [DATA_W-1:0] rl_data = '0;
  logic              rl_ready;
  logic [NUM_CH-1:0] ch_req = '0;
  logic [NUM_CH-1:0] ch_idle = '1;
  logic [NUM_CH-1:0] grant;
  logic [DATA_W-1:0] grant_row_len;
  logic [DIM_W-1:0]  grant_row_idx;
  logic              spmv_init, busy, done;
  logic [DIM_W-1:0]  stat_rows;
  logic [31:0]       stat_stalls;
  logic [1:0]        state_dbg;

  spmv_row_dispatch #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows),
    .rl_valid(rl_valid), .rl_data(rl_data), .rl_ready(rl_ready),
    .ch_req(ch_req), .ch_idle(ch_idle), .grant(grant),
    .grant_row_len(grant_row_len), .grant_row_idx(grant_row_idx),
    .spmv_init(spmv_init), .busy(busy), .done(done),
    .stat_rows(stat_rows), .stat_stalls(stat_stalls), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- directed cycle table ----------------
  typedef struct {
    logic        start;
    logic [15:0] num;
    logic        valid;
    logic [31:0] data;
    logic [3:0]  req;
    logic [3:0]  idle;
    logic        ready;
    logic [3:0]  grant;
    logic [31:0] len;
    logic [15:0] idx;
    logic        busy;
    logic        done;
    logic        init;
  } vec_t;
  vec_t vecs[$];

  // ---------------- reference model ----------------
  logic [DATA_W+DIM_W+NUM_CH-1:0] exp_q[$];
  int          m_ptr = 0;
  logic [3:0]  m_prev = '0;
  logic [15:0] m_idx = '0;
  int          m_num = 0, m_issued = 0, m_rows = 0, m_stalls = 0;
  bit          m_issuing = 1'b0, m_init = 1'b0;

  task automatic run_cycle(input logic v, input logic [3:0] req, input logic [31:0] d,
                           input logic [3:0] idle);
    logic [3:0] elig;
    logic       exp_ready;
    int         w;
    @(negedge clk);
    start = 1'b0; rl_valid = v; ch_req = req; rl_data = d; ch_idle = idle;
    #1;
    if (exp_q.size() != 0) chk("grant_row", {grant, grant_row_len, grant_row_idx}, exp_q.pop_front());
    else chk("no_grant", grant, 0);
    chk("spmv_init", spmv_init, m_init);
    m_init = 1'b0;
    elig = req & ~m_prev;
    exp_ready = m_issuing && v && (elig != 0);
    chk("rl_ready", rl_ready, exp_ready);
    if (m_issuing) begin
      chk("busy_run", busy, 1);
      chk("done_early", done, 0);
      if (v && elig == 0) m_stalls++;
    end
    m_prev = '0;
    if (exp_ready) begin
      w = -1;
      for (int k = 0; k < NUM_CH; k++) begin
        int c;
        c = (m_ptr + k) % NUM_CH;
        if (w < 0 && elig[c]) w = c;
      end
      m_prev = 4'(1 << w);
      exp_q.push_back({m_prev, d, m_idx});
      m_ptr = (w + 1) % NUM_CH;
      m_idx = m_idx + 16'd1;
      m_issued++;
      m_rows++;
      if (m_issued == m_num) m_issuing = 1'b0;
    end
  endtask

  task automatic start_job(input logic [15:0] n);
    @(negedge clk);
    start = 1'b1; num_rows = n; rl_valid = 1'b0; ch_req = '0; ch_idle = '1;
    #1;
    chk("idle_ready", rl_ready, 0);
    chk("idle_busy", busy, 0);
    m_num = n; m_issued = 0; m_idx = '0; m_rows = 0; m_stalls = 0;
    m_issuing = (n != 0); m_init = 1'b1; m_prev = '0;
  endtask

  task automatic finish_job();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 150 && !seen; i++) begin
      run_cycle(1'($urandom_range(0, 1)), 4'($urandom), $urandom,
                ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF);
      if (!m_issuing && done) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
    if (seen) begin
      chk("busy_at_done", busy, 0);
      chk("stat_rows", stat_rows, STATS ? m_rows : 0);
      chk("stat_stalls", stat_stalls, STATS ? m_stalls : 0);
    end
    run_cycle(1'b1, 4'hF, $urandom, 4'hF);
    chk("done_once", done, 0);
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_ready", rl_ready, 0);
    chk("rst_grant", grant, 0);
    chk("rst_len", grant_row_len, 0);
    chk("rst_idx", grant_row_idx, 0);
    chk("rst_init", spmv_init, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stats", {stat_rows, stat_stalls}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // start,num,valid,data,req,idle | ready,grant,len,idx,busy,done,init
    vecs.push_back('{1, 3, 0,  0, 'h0, 'hF, 0, 'h0,  0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 1,  5, 'hF, 'hF, 1, 'h0,  0, 0, 1, 0, 1});
    vecs.push_back('{0, 0, 1,  0, 'hF, 'hF, 1, 'h1,  5, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 1,  7, 'hF, 'hF, 1, 'h2,  0, 1, 1, 0, 0});
    vecs.push_back('{0, 0, 1,  9, 'hF, 'h7, 0, 'h4,  7, 2, 1, 0, 0});
    vecs.push_back('{0, 0, 1,  9, 'hF, 'h7, 0, 'h0,  7, 2, 1, 0, 0});
    vecs.push_back('{0, 0, 1,  9, 'hF, 'h7, 0, 'h0,  7, 2, 1, 0, 0});
    vecs.push_back('{0, 0, 1,  9, 'hF, 'h7, 0, 'h0,  7, 2, 1, 0, 0});
    vecs.push_back('{0, 0, 1,  9, 'hF, 'hF, 0, 'h0,  7, 2, 1, 0, 0});
    vecs.push_back('{0, 0, 0,  0, 'h0, 'hF, 0, 'h0,  7, 2, 0, 0, 0});
    vecs.push_back('{0, 0, 0,  0, 'h0, 'hF, 0, 'h0,  7, 2, 0, 1, 0});
    vecs.push_back('{0, 0, 0,  0, 'h0, 'hF, 0, 'h0,  7, 2, 0, 0, 0});
    vecs.push_back('{1, 0, 1,  0, 'hF, 'hF, 0, 'h0,  7, 2, 0, 0, 0});
    vecs.push_back('{0, 0, 1,  0, 'hF, 'hF, 0, 'h0,  7, 2, 0, 0, 1});
    vecs.push_back('{0, 0, 1,  0, 'hF, 'hF, 0, 'h0,  7, 2, 0, 1, 0});
    vecs.push_back('{0, 0, 1,  0, 'hF, 'hF, 0, 'h0,  7, 2, 0, 0, 0});
    vecs.push_back('{1, 3, 0,  0, 'h8, 'hF, 0, 'h0,  7, 2, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 11, 'h8, 'hF, 1, 'h0,  7, 2, 1, 0, 1});
    vecs.push_back('{0, 0, 1, 12, 'h8, 'hF, 0, 'h8, 11, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 1, 12, 'h8, 'hF, 1, 'h0, 11, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 1, 13, 'h8, 'hF, 0, 'h8, 12, 1, 1, 0, 0});
    vecs.push_back('{0, 0, 1, 13, 'h8, 'hF, 1, 'h0, 12, 1, 1, 0, 0});
    vecs.push_back('{1, 5, 1, 13, 'h8, 'hF, 0, 'h8, 13, 2, 1, 0, 0});
    vecs.push_back('{0, 0, 1,  0, 'h8, 'hF, 0, 'h0, 13, 2, 1, 0, 0});
    vecs.push_back('{0, 0, 0,  0, 'h0, 'hF, 0, 'h0, 13, 2, 0, 0, 0});
    vecs.push_back('{0, 0, 0,  0, 'h0, 'hF, 0, 'h0, 13, 2, 0, 1, 0});
    vecs.push_back('{0, 0, 0,  0, 'h0, 'hF, 0, 'h0, 13, 2, 0, 0, 0});

    foreach (vecs[i]) begin
      @(negedge clk);
      start = vecs[i].start; num_rows = vecs[i].num; rl_valid = vecs[i].valid;
      rl_data = vecs[i].data; ch_req = vecs[i].req; ch_idle = vecs[i].idle;
      #1;
      chk($sformatf("tv%0d_ready", i), rl_ready, vecs[i].ready);
      chk($sformatf("tv%0d_grant", i), grant, vecs[i].grant);
      chk($sformatf("tv%0d_len", i), grant_row_len, vecs[i].len);
      chk($sformatf("tv%0d_idx", i), grant_row_idx, vecs[i].idx);
      chk($sformatf("tv%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("tv%0d_done", i), done, vecs[i].done);
      chk($sformatf("tv%0d_init", i), spmv_init, vecs[i].init);
    end
    // table leaves the round-robin pointer at channel 0 after ch3's last grant
    m_ptr = 0;

    // stall counting: three cycles with data but no requesters, then two rows
    start_job(16'd2);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 4'h0, $urandom, 4'hF);
    run_cycle(1'b1, 4'hF, 32'd100, 4'hF);
    run_cycle(1'b1, 4'hF, 32'd101, 4'hF);
    finish_job();
    chk("stalls_three", stat_stalls, STATS ? 3 : 0);
    chk("rows_two", stat_rows, STATS ? 2 : 0);

    // randomized jobs, including empty ones
    for (int j = 0; j < 30; j++) begin
      start_job(16'($urandom_range(0, 10)));
      finish_job();
    end

    // reset in the middle of a job after two of six rows
    start_job(16'd6);
    run_cycle(1'b1, 4'hF, 32'd21, 4'hF);
    run_cycle(1'b1, 4'hF, 32'd22, 4'hF);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", rl_ready, 0);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_len", grant_row_len, 0);
    chk("mid_rst_idx", grant_row_idx, 0);
    chk("mid_rst_init", spmv_init, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_stats", {stat_rows, stat_stalls}, 0);
    exp_q.delete();
    m_issuing = 1'b0; m_ptr = 0; m_prev = '0; m_init = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b1, 4'hF, $urandom, 4'hF);
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end
    start_job(16'd2);
    run_cycle(1'b1, 4'hF, 32'd77, 4'hF);
    run_cycle(1'b0, 4'hF, 32'd0, 4'hF);
    chk("restart_idx0", grant_row_idx, 0);
    chk("restart_ch0", grant, 4'h1);
    finish_job();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
